// File: rtl/rv32i_pkg.sv
// Shared register-file types for the writeback path.
package rv32i_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned NREG = 32;

    typedef logic [4:0] reg_addr_t;

    typedef struct packed {
        reg_addr_t       rd;
        logic [XLEN-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO of writeback entries; extra pointer bit separates full from empty.
module wb_fifo
    import rv32i_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  logic      pop,
    input  wb_entry_t wentry,
    output wb_entry_t head,
    output logic      full,
    output logic      empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [AW:0] wptr_q;
    logic [AW:0] rptr_q;
    wb_entry_t   mem_q [DEPTH];

    // Pointer update; pointers wrap naturally at 2*DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + PTR_ONE;
            if (pop)  rptr_q <= rptr_q + PTR_ONE;
        end
    end

    // Storage needs no reset; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q[AW-1:0]] <= wentry;
    end

    assign head  = mem_q[rptr_q[AW-1:0]];
    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

endmodule

// File: rtl/rf_writeback.sv
// Register-file write initiator: ALU/load arbitration, load buffering and pending scoreboard.
module rf_writeback
    import rv32i_pkg::*;
#(
    parameter int unsigned LD_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            issue_valid,
    input  reg_addr_t       issue_rd,
    input  reg_addr_t       issue_rs1,
    input  reg_addr_t       issue_rs2,
    output logic            issue_stall,
    input  logic            alu_valid,
    input  reg_addr_t       alu_rd,
    input  logic [XLEN-1:0] alu_data,
    input  logic            ld_valid,
    output logic            ld_ready,
    input  reg_addr_t       ld_rd,
    input  logic [XLEN-1:0] ld_data,
    output reg_addr_t       waddr,
    output logic [XLEN-1:0] wdata,
    output logic            regwen,
    output logic [NREG-1:0] pending
);

    wb_entry_t       ld_entry;
    wb_entry_t       fifo_head;
    wb_entry_t       sel;
    logic            sel_valid;
    logic            sel_wen;
    logic            fifo_full;
    logic            fifo_empty;
    logic            fifo_push;
    logic            fifo_pop;
    logic            ld_accept;
    logic            bypass;
    logic            issue_accept;
    logic [NREG-1:0] pending_d;

    assign ld_entry  = {ld_rd, ld_data};
    assign ld_ready  = ~fifo_full;
    assign ld_accept = ld_valid & ld_ready;
    // Empty buffer and idle ALU: write the arriving load straight through.
    assign bypass    = ld_accept & fifo_empty & ~alu_valid;
    assign fifo_push = ld_accept & ~bypass;
    assign fifo_pop  = ~alu_valid & ~fifo_empty;

    wb_fifo #(
        .DEPTH (LD_DEPTH)
    ) u_ld_fifo (
        .clk    (clk),
        .rst    (rst),
        .push   (fifo_push),
        .pop    (fifo_pop),
        .wentry (ld_entry),
        .head   (fifo_head),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    // Write-port arbitration: ALU first, then buffered load, then bypassed load.
    always_comb begin
        sel       = '0;
        sel_valid = 1'b0;
        if (alu_valid) begin
            sel       = {alu_rd, alu_data};
            sel_valid = 1'b1;
        end else if (!fifo_empty) begin
            sel       = fifo_head;
            sel_valid = 1'b1;
        end else if (ld_accept) begin
            sel       = ld_entry;
            sel_valid = 1'b1;
        end
    end

    // x0 results are consumed but never reach the register file.
    assign sel_wen = sel_valid & (sel.rd != '0);

    // Hazard check uses only the registered scoreboard.
    always_comb begin
        issue_stall = issue_valid &
                      ((pending[issue_rs1] & (issue_rs1 != '0)) |
                       (pending[issue_rs2] & (issue_rs2 != '0)) |
                       (pending[issue_rd]  & (issue_rd  != '0)));
    end

    assign issue_accept = issue_valid & ~issue_stall;

    // Scoreboard next state: commit clears, accepted issue sets (set wins).
    always_comb begin
        pending_d = pending;
        if (regwen) pending_d[waddr] = 1'b0;
        if (issue_accept && (issue_rd != '0)) pending_d[issue_rd] = 1'b1;
        pending_d[0] = 1'b0;
    end

    // Registered write port and scoreboard; address/data hold when not writing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            waddr   <= '0;
            wdata   <= '0;
            regwen  <= 1'b0;
            pending <= '0;
        end else begin
            pending <= pending_d;
            regwen  <= sel_wen;
            if (sel_wen) begin
                waddr <= sel.rd;
                wdata <= sel.data;
            end
        end
    end

endmodule

// File: tb/tb_rf_writeback.sv
// Self-checking bench for rf_writeback: directed plan steps plus randomized traffic vs a queue model.
module tb_rf_writeback;
    import rv32i_pkg::*;

    localparam int unsigned LD_DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid;
    logic [4:0]  issue_rd, issue_rs1, issue_rs2;
    logic        issue_stall;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        ld_valid;
    logic        ld_ready;
    logic [4:0]  ld_rd;
    logic [31:0] ld_data;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        regwen;
    logic [31:0] pending;

    int nerr = 0;
    int nchecks = 0;

    // Reference model state
    logic [36:0] ldq[$];
    logic [31:0] m_pend;
    logic        m_regwen;
    logic [4:0]  m_waddr;
    logic [31:0] m_wdata;

    always #5 clk = ~clk;

    rf_writeback #(
        .LD_DEPTH (LD_DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .issue_rs1   (issue_rs1),
        .issue_rs2   (issue_rs2),
        .issue_stall (issue_stall),
        .alu_valid   (alu_valid),
        .alu_rd      (alu_rd),
        .alu_data    (alu_data),
        .ld_valid    (ld_valid),
        .ld_ready    (ld_ready),
        .ld_rd       (ld_rd),
        .ld_data     (ld_data),
        .waddr       (waddr),
        .wdata       (wdata),
        .regwen      (regwen),
        .pending     (pending)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchecks++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        ldq.delete();
        m_pend   = '0;
        m_regwen = 1'b0;
        m_waddr  = '0;
        m_wdata  = '0;
    endtask

    task automatic check_regs();
        chk("regwen", {63'd0, regwen}, {63'd0, m_regwen});
        chk("waddr", {59'd0, waddr}, {59'd0, m_waddr});
        chk("wdata", {32'd0, wdata}, {32'd0, m_wdata});
        chk("pending", {32'd0, pending}, {32'd0, m_pend});
    endtask

    // One clock cycle: drive, check combinational outputs, advance model, check registers.
    task automatic cycle(input logic iv, input logic [4:0] ird, input logic [4:0] irs1,
                         input logic [4:0] irs2, input logic av, input logic [4:0] ard,
                         input logic [31:0] ad, input logic lv, input logic [4:0] lrd,
                         input logic [31:0] ldat, output logic ld_took);
        logic        exp_stall;
        logic        exp_ready;
        logic [31:0] nxt_pend;
        logic [36:0] wr;
        logic        have;
        issue_valid = iv; issue_rd = ird; issue_rs1 = irs1; issue_rs2 = irs2;
        alu_valid = av; alu_rd = ard; alu_data = ad;
        ld_valid = lv; ld_rd = lrd; ld_data = ldat;
        #1;
        exp_stall = iv && ((m_pend[irs1] && irs1 != 0) || (m_pend[irs2] && irs2 != 0) ||
                           (m_pend[ird] && ird != 0));
        exp_ready = (ldq.size() < LD_DEPTH);
        chk("issue_stall", {63'd0, issue_stall}, {63'd0, exp_stall});
        chk("ld_ready", {63'd0, ld_ready}, {63'd0, exp_ready});
        ld_took = lv && exp_ready;
        nxt_pend = m_pend;
        if (m_regwen) nxt_pend[m_waddr] = 1'b0;
        if (iv && !exp_stall && ird != 0) nxt_pend[ird] = 1'b1;
        // Loads join the queue first; the write port then takes ALU or the oldest load.
        if (ld_took) ldq.push_back({lrd, ldat});
        have = 1'b0;
        wr   = '0;
        if (av) begin
            wr = {ard, ad}; have = 1'b1;
        end else if (ldq.size() > 0) begin
            wr = ldq.pop_front(); have = 1'b1;
        end
        m_regwen = have && (wr[36:32] != 0);
        if (m_regwen) begin
            m_waddr = wr[36:32];
            m_wdata = wr[31:0];
        end
        m_pend = nxt_pend;
        @(posedge clk);
        #1;
        check_regs();
    endtask

    task automatic idle(output logic took);
        cycle(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, took);
    endtask

    initial begin
        logic        took;
        logic [4:0]  order[$];
        logic [4:0]  lds[3];
        int          li;
        logic        rv, ra, rl;
        logic [4:0]  rrd, r1, r2, rard, rlrd;
        logic [31:0] rad, rld;

        rst = 1'b1;
        issue_valid = 0; issue_rd = 0; issue_rs1 = 0; issue_rs2 = 0;
        alu_valid = 0; alu_rd = 0; alu_data = 0;
        ld_valid = 0; ld_rd = 0; ld_data = 0;
        model_reset();

        // 1. Reset and ALU write
        #2;
        chk("rst_regwen", {63'd0, regwen}, 64'd0);
        chk("rst_waddr", {59'd0, waddr}, 64'd0);
        chk("rst_wdata", {32'd0, wdata}, 64'd0);
        chk("rst_pending", {32'd0, pending}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        cycle(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, took);
        chk("t1_regwen", {63'd0, regwen}, 64'd1);
        chk("t1_waddr", {59'd0, waddr}, 64'd5);
        chk("t1_wdata", {32'd0, wdata}, 64'hDEADBEEF);

        // 2. RAW stall cleared by a load to x3
        cycle(1'b1, 5'd3, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, took);
        chk("t2_pend3", {63'd0, pending[3]}, 64'd1);
        cycle(1'b1, 5'd0, 5'd3, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, took);
        cycle(1'b1, 5'd0, 5'd3, 5'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'h11, took);
        chk("t2_wr_x3", {59'd0, waddr}, 64'd3);
        cycle(1'b1, 5'd0, 5'd3, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, took);
        chk("t2_pend3_clr", {63'd0, pending[3]}, 64'd0);
        issue_valid = 1'b1; issue_rs1 = 5'd3; #1;
        chk("t2_stall_drop", {63'd0, issue_stall}, 64'd0);
        idle(took);

        // 3. Contention: ALU wins, load follows
        cycle(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 5'd1, 32'hA1A1A1A1, 1'b1, 5'd2, 32'hB2B2B2B2, took);
        chk("t3_first", {59'd0, waddr}, 64'd1);
        idle(took);
        chk("t3_second", {59'd0, waddr}, 64'd2);
        chk("t3_second_d", {32'd0, wdata}, 64'hB2B2B2B2);
        idle(took);

        // 4. Buffer fills behind a busy ALU, then drains in arrival order
        lds[0] = 5'd4; lds[1] = 5'd6; lds[2] = 5'd7;
        li = 0;
        for (int i = 0; i < 9; i++) begin
            cycle(1'b0, 5'd0, 5'd0, 5'd0, (i < 4), 5'd8 + 5'(i), 32'h100 + i,
                  (li < 3), lds[li % 3], 32'h200 + li, took);
            if (took) li++;
            if (i == 1) chk("t4_full", {63'd0, ld_ready}, 64'd0);
            if (i >= 4 && regwen) order.push_back(waddr);
        end
        chk("t4_count", 64'(order.size()), 64'd3);
        if (order.size() == 3) begin
            chk("t4_ord0", {59'd0, order[0]}, 64'd4);
            chk("t4_ord1", {59'd0, order[1]}, 64'd6);
            chk("t4_ord2", {59'd0, order[2]}, 64'd7);
        end

        // 5. x0 handling
        cycle(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 5'd0, 32'h55, 1'b0, 5'd0, 32'd0, took);
        chk("t5_regwen", {63'd0, regwen}, 64'd0);
        chk("t5_pend", {32'd0, pending}, 64'd0);

        // 6. Reset while loads are buffered and x4 is pending
        cycle(1'b1, 5'd4, 5'd0, 5'd0, 1'b1, 5'd10, 32'h10, 1'b1, 5'd4, 32'h44, took);
        cycle(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 5'd11, 32'h11, 1'b1, 5'd9, 32'h99, took);
        chk("t6_pend4", {63'd0, pending[4]}, 64'd1);
        issue_valid = 0; alu_valid = 0; ld_valid = 0;
        rst = 1'b1;
        #1;
        chk("t6_regwen", {63'd0, regwen}, 64'd0);
        chk("t6_pending", {32'd0, pending}, 64'd0);
        chk("t6_ready", {63'd0, ld_ready}, 64'd1);
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) idle(took);

        // Randomized traffic with a load producer that holds until accepted
        rl = 1'b0; rlrd = 0; rld = 0;
        for (int i = 0; i < 400; i++) begin
            rv   = ($urandom_range(99) < 50);
            rrd  = 5'($urandom_range(7));
            r1   = 5'($urandom_range(7));
            r2   = 5'($urandom_range(7));
            ra   = ($urandom_range(99) < 35);
            rard = 5'($urandom_range(7));
            rad  = $urandom;
            if (!rl) begin
                rl   = ($urandom_range(99) < 45);
                rlrd = 5'($urandom_range(7));
                rld  = $urandom;
            end
            cycle(rv, rrd, r1, r2, ra, rard, rad, rl, rlrd, rld, took);
            if (took) rl = 1'b0;
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchecks);
        $finish;
    end

endmodule
